// File: rtl/bictr_seq_pkg.sv
// Shared types and constants for the counter sequencing controller.
// Holds the FSM state encoding, the default counter width and the pass-count width.
package bictr_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REPS_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bictr_seq_ctrl.sv
// Sequencer driving a 4-bit up/down counter through repeated start->end passes; one-cycle FSM response, cen gated by tercnt.
// Optional ping-pong mode under BICTR_SEQ_BOUNCE_EN: passes alternate direction instead of reloading.
module bictr_seq_ctrl
  import bictr_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic [REPS_W-1:0] reps,
  input  logic              tercnt,
  output logic [WIDTH-1:0]  data,
  output logic              load,
  output logic              up_dn,
  output logic              cen,
  output logic [WIDTH-1:0]  count_to,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [REPS_W-1:0] pass
);

  state_t              state_q, state_d;
  logic [REPS_W-1:0]   pass_q, pass_d;
  logic [REPS_W-1:0]   reps_q;
  logic [WIDTH-1:0]    start_q, end_q;
  logic [WIDTH-1:0]    tgt_q, tgt_d;
  logic                dir_q, dir_d;
  logic                abort_d, aborted_q;
  logic                latch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pass_q    <= '0;
      reps_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      tgt_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      tgt_q     <= tgt_d;
      dir_q     <= dir_d;
      aborted_q <= abort_d;
      if (latch) begin
        start_q <= start_val;
        end_q   <= end_val;
        reps_q  <= reps;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    abort_d = 1'b0;
    latch   = 1'b0;
    data    = '0;
    load    = 1'b0;
    up_dn   = 1'b0;
    cen     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          dir_d   = dir;
          pass_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data  = start_q;
        tgt_d = end_q;
        if (stop) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          cen     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        up_dn = dir_q;
        if (stop) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Holding cen low on the terminal cycle parks the counter on the end value.
          cen = ~tercnt;
          if (tercnt) begin
            if (pass_q == reps_q) begin
              state_d = DONE;
            end else begin
              pass_d = pass_q + 1'b1;
`ifdef BICTR_SEQ_BOUNCE_EN
              dir_d  = ~dir_q;
              tgt_d  = (tgt_q == end_q) ? start_q : end_q;
`else
              state_d = LOAD;
`endif
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_to = (state_q == LOAD) ? end_q : tgt_q;
  assign busy     = (state_q != IDLE);
  assign aborted  = aborted_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_bictr_seq_ctrl.sv
// Directed bench for bictr_seq_ctrl with a behavioural 4-bit up/down counter closing the tercnt loop.
// Build with BICTR_SEQ_BOUNCE_EN defined to exercise ping-pong mode instead of the reload-based passes.
module tb_bictr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [3:0] start_val = '0, end_val = '0, reps = '0;
  logic       tercnt;
  logic [3:0] data, count_to, pass;
  logic       load, up_dn, cen, busy, done, aborted;
  logic [3:0] cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bictr_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .start_val(start_val), .end_val(end_val), .reps(reps), .tercnt(tercnt),
    .data(data), .load(load), .up_dn(up_dn), .cen(cen), .count_to(count_to),
    .busy(busy), .done(done), .aborted(aborted), .pass(pass)
  );

  // Counter model: loads only with load=1 and up_dn=0, otherwise steps while enabled.
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (cen) begin
      if (load && !up_dn) cnt <= data;
      else if (up_dn)     cnt <= cnt + 4'd1;
      else                cnt <= cnt - 4'd1;
    end
  end
  assign tercnt = (cnt == count_to);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string t, input int c, input logic [3:0] e_cnt,
                      input logic e_load, input logic e_cen, input logic e_updn,
                      input logic e_done, input logic [3:0] e_pass,
                      input logic e_busy, input logic e_abrt);
    chk($sformatf("%s.c%0d.cnt", t, c),  cnt,     e_cnt);
    chk($sformatf("%s.c%0d.load", t, c), load,    e_load);
    chk($sformatf("%s.c%0d.cen", t, c),  cen,     e_cen);
    chk($sformatf("%s.c%0d.updn", t, c), up_dn,   e_updn);
    chk($sformatf("%s.c%0d.done", t, c), done,    e_done);
    chk($sformatf("%s.c%0d.pass", t, c), pass,    e_pass);
    chk($sformatf("%s.c%0d.busy", t, c), busy,    e_busy);
    chk($sformatf("%s.c%0d.abrt", t, c), aborted, e_abrt);
  endtask

  task automatic go(input logic d, input logic [3:0] s, input logic [3:0] e, input logic [3:0] r);
    dir = d; start_val = s; end_val = e; reps = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1;
    outs("rst", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
    chk("rst.data", data, 4'd0);
    chk("rst.count_to", count_to, 4'd0);
    tick(); tick();
    reset = 1'b0;

    // Down with wrap 1 -> 0 -> 15 -> 14, single pass
    go(1'b0, 4'd1, 4'd14, 4'd0);
    outs("dn", 1, 4'd0, 1, 1, 0, 0, 4'd0, 1, 0);
    chk("dn.data", data, 4'd1);
    chk("dn.count_to", count_to, 4'd14);
    tick(); outs("dn", 2, 4'd1,  0, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("dn", 3, 4'd0,  0, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("dn", 4, 4'd15, 0, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("dn", 5, 4'd14, 0, 0, 0, 0, 4'd0, 1, 0);
    tick(); outs("dn", 6, 4'd14, 0, 0, 0, 1, 4'd0, 1, 0);
    tick(); outs("dn", 7, 4'd14, 0, 0, 0, 0, 4'd0, 0, 0);

    // Stop on third RUN cycle of up 0 -> 10, with a start pulse while busy
    go(1'b1, 4'd0, 4'd10, 4'd0);
    outs("stp", 1, 4'd14, 1, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("stp", 2, 4'd0, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("stp", 3, 4'd1, 0, 1, 1, 0, 4'd0, 1, 0);
    start_val = 4'd7; end_val = 4'd12; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    #1;
    outs("stp", 4, 4'd2, 0, 0, 1, 0, 4'd0, 1, 0);
    chk("stp.ignored_start", count_to, 4'd10);
    tick();
    stop = 1'b0;
    outs("stp", 5, 4'd2, 0, 0, 0, 0, 4'd0, 0, 1);
    chk("stp.count_to_hold", count_to, 4'd10);
    tick(); outs("stp", 6, 4'd2, 0, 0, 0, 0, 4'd0, 0, 0);

`ifndef BICTR_SEQ_BOUNCE_EN
    // Up 3 -> 6, two passes, each reloaded
    go(1'b1, 4'd3, 4'd6, 4'd1);
    outs("up", 1, 4'd2, 1, 1, 0, 0, 4'd0, 1, 0);
    chk("up.data", data, 4'd3);
    tick(); outs("up", 2,  4'd3, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("up", 3,  4'd4, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("up", 4,  4'd5, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("up", 5,  4'd6, 0, 0, 1, 0, 4'd0, 1, 0);
    tick(); outs("up", 6,  4'd6, 1, 1, 0, 0, 4'd1, 1, 0);
    tick(); outs("up", 7,  4'd3, 0, 1, 1, 0, 4'd1, 1, 0);
    tick(); outs("up", 8,  4'd4, 0, 1, 1, 0, 4'd1, 1, 0);
    tick(); outs("up", 9,  4'd5, 0, 1, 1, 0, 4'd1, 1, 0);
    tick(); outs("up", 10, 4'd6, 0, 0, 1, 0, 4'd1, 1, 0);
    tick(); outs("up", 11, 4'd6, 0, 0, 0, 1, 4'd1, 1, 0);
    tick(); outs("up", 12, 4'd6, 0, 0, 0, 0, 4'd1, 0, 0);

    // start == end == 9, three passes of two cycles
    go(1'b1, 4'd9, 4'd9, 4'd2);
    outs("eq", 1, 4'd6, 1, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("eq", 2, 4'd9, 0, 0, 1, 0, 4'd0, 1, 0);
    tick(); outs("eq", 3, 4'd9, 1, 1, 0, 0, 4'd1, 1, 0);
    tick(); outs("eq", 4, 4'd9, 0, 0, 1, 0, 4'd1, 1, 0);
    tick(); outs("eq", 5, 4'd9, 1, 1, 0, 0, 4'd2, 1, 0);
    tick(); outs("eq", 6, 4'd9, 0, 0, 1, 0, 4'd2, 1, 0);
    tick(); outs("eq", 7, 4'd9, 0, 0, 0, 1, 4'd2, 1, 0);
    tick(); outs("eq", 8, 4'd9, 0, 0, 0, 0, 4'd2, 0, 0);

    // Reset during second pass, then a clean rerun
    go(1'b1, 4'd4, 4'd5, 4'd1);
    outs("rs", 1, 4'd9, 1, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("rs", 2, 4'd4, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("rs", 3, 4'd5, 0, 0, 1, 0, 4'd0, 1, 0);
    tick(); outs("rs", 4, 4'd5, 1, 1, 0, 0, 4'd1, 1, 0);
    tick(); outs("rs", 5, 4'd4, 0, 1, 1, 0, 4'd1, 1, 0);
    reset = 1'b1;
    #1;
    outs("rs", 6, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
    chk("rs.data", data, 4'd0);
    chk("rs.count_to", count_to, 4'd0);
    tick();
    reset = 1'b0;
    go(1'b1, 4'd4, 4'd5, 4'd0);
    outs("rr", 1, 4'd0, 1, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("rr", 2, 4'd4, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("rr", 3, 4'd5, 0, 0, 1, 0, 4'd0, 1, 0);
    tick(); outs("rr", 4, 4'd5, 0, 0, 0, 1, 4'd0, 1, 0);
    tick(); outs("rr", 5, 4'd5, 0, 0, 0, 0, 4'd0, 0, 0);
`else
    // Ping-pong up 2 -> 5 then back to 2 with a single LOAD
    go(1'b1, 4'd2, 4'd5, 4'd1);
    outs("bn", 1, 4'd2, 1, 1, 0, 0, 4'd0, 1, 0);
    tick(); outs("bn", 2,  4'd2, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("bn", 3,  4'd3, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("bn", 4,  4'd4, 0, 1, 1, 0, 4'd0, 1, 0);
    tick(); outs("bn", 5,  4'd5, 0, 0, 1, 0, 4'd0, 1, 0);
    tick(); outs("bn", 6,  4'd5, 0, 1, 0, 0, 4'd1, 1, 0);
    chk("bn.count_to", count_to, 4'd2);
    tick(); outs("bn", 7,  4'd4, 0, 1, 0, 0, 4'd1, 1, 0);
    tick(); outs("bn", 8,  4'd3, 0, 1, 0, 0, 4'd1, 1, 0);
    tick(); outs("bn", 9,  4'd2, 0, 0, 0, 0, 4'd1, 1, 0);
    tick(); outs("bn", 10, 4'd2, 0, 0, 0, 1, 4'd1, 1, 0);
    tick(); outs("bn", 11, 4'd2, 0, 0, 0, 0, 4'd1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
